// File: rtl/data_structures_pkg.sv
// Shared datapath types: operand/tag widths, ALU opcodes, flags and the
// ALU result entry that is buffered toward the ROB.
`ifndef GPR_SIZE
`define GPR_SIZE 64
`endif
`ifndef ROB_IDX_SIZE
`define ROB_IDX_SIZE 5
`endif

package data_structures;

  typedef enum logic [3:0] {
    PLUS   = 4'd0,
    MINUS  = 4'd1,
    AND    = 4'd2,
    ORR    = 4'd3,
    EOR    = 4'd4,
    LSL    = 4'd5,
    LSR    = 4'd6,
    ASR    = 4'd7,
    PASS_A = 4'd8,
    MUL    = 4'd9
  } alu_op_t;

  typedef struct packed {
    logic n;
    logic z;
    logic c;
    logic v;
  } nzcv_t;

  typedef struct packed {
    logic [`GPR_SIZE-1:0]    value;
    logic [`ROB_IDX_SIZE-1:0] tag;
    logic                     set_nzcv;
    nzcv_t                    nzcv;
  } alu_result_t;

endpackage

// File: rtl/alu_result_fifo.sv
// Circular result buffer between the execute stage and the ROB, with a
// synchronous flush that empties it in one edge.
module alu_result_fifo
  import data_structures::*;
#(
  parameter int unsigned Depth = 4,
  localparam int unsigned PtrW = $clog2(Depth),
  localparam int unsigned CntW = $clog2(Depth + 1)
) (
  input  logic            in_clk,
  input  logic            in_rst,
  input  logic            in_flush,
  input  logic            in_push,
  input  alu_result_t     in_push_data,
  input  logic            in_pop,
  output alu_result_t     out_head,
  output logic [CntW-1:0] out_count,
  output logic            out_not_empty
);

  alu_result_t     mem_q [Depth];
  logic [PtrW-1:0] wptr_q, rptr_q;
  logic [CntW-1:0] count_q;
  logic            do_push, do_pop;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(Depth - 1)) ? '0 : p + 1'b1;
  endfunction

  // Empty pops are dropped so the count can never underflow.
  assign do_pop  = in_pop & (count_q != '0);
  assign do_push = in_push & ((count_q != CntW'(Depth)) | do_pop);

  // Pointer and occupancy state; flush wins over any push or pop.
  always_ff @(posedge in_clk or negedge in_rst) begin
    if (!in_rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else if (in_flush) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wptr_q <= ptr_inc(wptr_q);
      if (do_pop)  rptr_q <= ptr_inc(rptr_q);
      unique case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Entry storage; contents are only visible while counted as valid.
  always_ff @(posedge in_clk) begin
    if (do_push && !in_flush) mem_q[wptr_q] <= in_push_data;
  end

  assign out_head      = mem_q[rptr_q];
  assign out_count     = count_q;
  assign out_not_empty = (count_q != '0);

endmodule

// File: rtl/alu_func_unit.sv
// Single-cycle ALU functional unit: issue register, inline arithmetic and a
// result FIFO toward the ROB. Define ALU_FUNC_UNIT_MUL_EN to build the
// 64x64 multiplier for MUL; otherwise MUL is an unsupported op.
module alu_func_unit
  import data_structures::*;
#(
  parameter int unsigned RESULT_FIFO_DEPTH = 4
) (
  input  logic                     in_clk,
  input  logic                     in_rst,
  input  logic                     in_rs_start,
  input  alu_op_t                  in_rs_op,
  input  logic [`GPR_SIZE-1:0]     in_rs_val_a,
  input  logic [`GPR_SIZE-1:0]     in_rs_val_b,
  input  logic [`ROB_IDX_SIZE-1:0] in_rs_dst_rob_index,
  input  logic                     in_rs_set_nzcv,
  input  nzcv_t                    in_rs_nzcv,
  output logic                     out_rs_ready,
  output logic                     out_rob_done,
  output logic [`ROB_IDX_SIZE-1:0] out_rob_dst_rob_index,
  output logic [`GPR_SIZE-1:0]     out_rob_value,
  output logic                     out_rob_set_nzcv,
  output nzcv_t                    out_rob_nzcv,
  input  logic                     in_rob_ready,
  input  logic                     in_rob_is_mispred
);

  localparam int unsigned CntW = $clog2(RESULT_FIFO_DEPTH + 1);

  logic                     exec_valid_q;
  alu_op_t                  exec_op_q;
  logic [`GPR_SIZE-1:0]     exec_a_q, exec_b_q;
  logic [`ROB_IDX_SIZE-1:0] exec_tag_q;
  logic                     exec_set_q;
  nzcv_t                    exec_nzcv_q;

  logic            accept, push, pop;
  logic [CntW-1:0] fifo_count;
  logic            fifo_not_empty;
  logic [CntW:0]   occupancy;
  alu_result_t     exec_result, fifo_head;

  logic [`GPR_SIZE:0]   sum;
  logic [`GPR_SIZE-1:0] res;
  logic                 carry, ovf, supported;

  // Reserve a FIFO slot for the op sitting in execute, so pushes never stall.
  always_comb begin
    occupancy = {1'b0, fifo_count} + {{CntW{1'b0}}, exec_valid_q};
  end

  assign out_rs_ready = occupancy < (CntW + 1)'(RESULT_FIFO_DEPTH);
  assign accept       = in_rs_start & out_rs_ready & ~in_rob_is_mispred;
  assign push         = exec_valid_q & ~in_rob_is_mispred;
  assign pop          = fifo_not_empty & in_rob_ready & ~in_rob_is_mispred;

  // Execute-stage valid bit; a flush squashes the op being issued.
  always_ff @(posedge in_clk or negedge in_rst) begin
    if (!in_rst) exec_valid_q <= 1'b0;
    else         exec_valid_q <= accept;
  end

  // Execute-stage payload, only meaningful while exec_valid_q is set.
  always_ff @(posedge in_clk) begin
    if (accept) begin
      exec_op_q   <= in_rs_op;
      exec_a_q    <= in_rs_val_a;
      exec_b_q    <= in_rs_val_b;
      exec_tag_q  <= in_rs_dst_rob_index;
      exec_set_q  <= in_rs_set_nzcv;
      exec_nzcv_q <= in_rs_nzcv;
    end
  end

  // Result and flag computation from the execute register.
  always_comb begin
    sum       = '0;
    res       = '0;
    carry     = 1'b0;
    ovf       = 1'b0;
    supported = 1'b1;
    unique case (exec_op_q)
      PLUS: begin
        sum   = {1'b0, exec_a_q} + {1'b0, exec_b_q};
        res   = sum[`GPR_SIZE-1:0];
        carry = sum[`GPR_SIZE];
        ovf   = (exec_a_q[`GPR_SIZE-1] == exec_b_q[`GPR_SIZE-1]) &&
                (res[`GPR_SIZE-1] != exec_a_q[`GPR_SIZE-1]);
      end
      MINUS: begin
        // a + ~b + 1: carry-out set means no borrow.
        sum   = {1'b0, exec_a_q} + {1'b0, ~exec_b_q} + 1'b1;
        res   = sum[`GPR_SIZE-1:0];
        carry = sum[`GPR_SIZE];
        ovf   = (exec_a_q[`GPR_SIZE-1] != exec_b_q[`GPR_SIZE-1]) &&
                (res[`GPR_SIZE-1] != exec_a_q[`GPR_SIZE-1]);
      end
      AND:    res = exec_a_q & exec_b_q;
      ORR:    res = exec_a_q | exec_b_q;
      EOR:    res = exec_a_q ^ exec_b_q;
      LSL:    res = exec_a_q << exec_b_q[5:0];
      LSR:    res = exec_a_q >> exec_b_q[5:0];
      ASR:    res = $signed(exec_a_q) >>> exec_b_q[5:0];
      PASS_A: res = exec_a_q;
`ifdef ALU_FUNC_UNIT_MUL_EN
      MUL:    res = exec_a_q * exec_b_q;
`else
      MUL:    supported = 1'b0;
`endif
      default: supported = 1'b0;
    endcase

    exec_result.value    = supported ? res : '0;
    exec_result.tag      = exec_tag_q;
    exec_result.set_nzcv = supported & exec_set_q;
    exec_result.nzcv     = exec_nzcv_q;
    if (exec_result.set_nzcv) begin
      exec_result.nzcv = '{n: res[`GPR_SIZE-1], z: (res == '0), c: carry, v: ovf};
    end
  end

  alu_result_fifo #(
    .Depth (RESULT_FIFO_DEPTH)
  ) u_result_fifo (
    .in_clk        (in_clk),
    .in_rst        (in_rst),
    .in_flush      (in_rob_is_mispred),
    .in_push       (push),
    .in_push_data  (exec_result),
    .in_pop        (pop),
    .out_head      (fifo_head),
    .out_count     (fifo_count),
    .out_not_empty (fifo_not_empty)
  );

  // Outputs are zeroed whenever nothing is valid, which also covers reset.
  always_comb begin
    out_rob_done          = fifo_not_empty;
    out_rob_value         = fifo_not_empty ? fifo_head.value : '0;
    out_rob_dst_rob_index = fifo_not_empty ? fifo_head.tag : '0;
    out_rob_set_nzcv      = fifo_not_empty & fifo_head.set_nzcv;
    out_rob_nzcv          = fifo_not_empty ? fifo_head.nzcv : '0;
  end

endmodule
